// File: rtl/vga_sync_monitor.sv
// Receive-side VGA sync monitor: recovers pixel coordinates from HS/VS/valid,
// measures line and frame geometry and tracks lock against the expected mode.
module vga_sync_monitor #(
    parameter int P_WIDTH  = 11,
    parameter int H_PERIOD = 800,
    parameter int V_PERIOD = 525,
    parameter int H_ACT    = 640,
    parameter int V_ACT    = 480
) (
    input  logic               VGA_CLK,
    input  logic               RST,
    input  logic               VGA_HS,
    input  logic               VGA_VS,
    input  logic               valid_in,
    output logic [P_WIDTH-1:0] X,
    output logic [P_WIDTH-1:0] Y,
    output logic               de_out,
    output logic               frame_start,
    output logic [P_WIDTH-1:0] h_period,
    output logic [P_WIDTH-1:0] v_lines,
    output logic [P_WIDTH-1:0] act_width,
    output logic [P_WIDTH-1:0] act_height,
    output logic               locked,
    output logic               err_flag,
    output logic [7:0]         err_count
);

    localparam logic [P_WIDTH-1:0] C_MAX      = '1;
    localparam logic [P_WIDTH-1:0] C_ONE      = P_WIDTH'(1);
    localparam logic [P_WIDTH-1:0] C_H_PERIOD = P_WIDTH'(H_PERIOD);
    localparam logic [P_WIDTH-1:0] C_V_PERIOD = P_WIDTH'(V_PERIOD);
    localparam logic [P_WIDTH-1:0] C_H_ACT    = P_WIDTH'(H_ACT);
    localparam logic [P_WIDTH-1:0] C_V_ACT    = P_WIDTH'(V_ACT);

    typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

    function automatic logic [P_WIDTH-1:0] sat_inc(input logic [P_WIDTH-1:0] v);
        return (v == C_MAX) ? v : v + C_ONE;
    endfunction

    logic               r_s_hs, r_d_hs, r_s_vs, r_d_vs, r_s_valid;
    logic [P_WIDTH-1:0] r_h_cnt, r_w_cnt, r_line_cnt, r_act_cnt;
    state_t             r_state, w_state_nx;
    logic               w_loss;

    logic               w_hs_fall, w_vs_fall, w_line_act, w_line_end;
    logic [P_WIDTH-1:0] w_h_meas, w_h_period_nx, w_act_width_nx, w_lines_nx, w_act_h_nx;
    logic               w_frame_ok, w_line_bad, w_sync_lost;

    assign w_hs_fall  = r_d_hs & ~r_s_hs;
    assign w_vs_fall  = r_d_vs & ~r_s_vs;
    assign w_line_act = (r_w_cnt != '0);
    assign w_line_end = w_hs_fall & w_line_act;

    // Values as they will read after this edge; a coincident HS fall is folded
    // in before VS latches. act_width only tracks lines that carried video, so
    // the blank lines ahead of VS do not overwrite the measured active width.
    assign w_h_meas        = sat_inc(r_h_cnt);
    assign w_h_period_nx   = w_hs_fall  ? w_h_meas           : h_period;
    assign w_act_width_nx  = w_line_end ? r_w_cnt            : act_width;
    assign w_lines_nx      = w_hs_fall  ? sat_inc(r_line_cnt) : r_line_cnt;
    assign w_act_h_nx      = w_line_end ? sat_inc(r_act_cnt)  : r_act_cnt;

    assign w_frame_ok  = (w_h_period_nx == C_H_PERIOD) && (w_lines_nx == C_V_PERIOD) &&
                         (w_act_width_nx == C_H_ACT) && (w_act_h_nx == C_V_ACT);
    assign w_line_bad  = w_line_end && ((w_h_meas != C_H_PERIOD) || (r_w_cnt != C_H_ACT));
    assign w_sync_lost = (r_h_cnt == C_MAX) && !w_hs_fall;

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        w_state_nx = r_state;
        w_loss     = 1'b0;
        case (r_state)
            S_SEARCH:  if (w_vs_fall) w_state_nx = S_MEASURE;
            S_MEASURE: if (w_vs_fall && w_frame_ok) w_state_nx = S_LOCKED;
            S_LOCKED: begin
                if (w_line_bad || w_sync_lost || (w_vs_fall && !w_frame_ok)) begin
                    w_loss     = 1'b1;
                    w_state_nx = S_SEARCH;
                end
            end
            default:   w_state_nx = S_SEARCH;
        endcase
    end

    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) r_state <= S_SEARCH;
        else     r_state <= w_state_nx;
    end

    assign locked = (r_state == S_LOCKED);

    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            r_s_hs      <= 1'b1;
            r_d_hs      <= 1'b1;
            r_s_vs      <= 1'b1;
            r_d_vs      <= 1'b1;
            r_s_valid   <= 1'b0;
            r_h_cnt     <= '0;
            r_w_cnt     <= '0;
            r_line_cnt  <= '0;
            r_act_cnt   <= '0;
            X           <= '0;
            Y           <= '0;
            de_out      <= 1'b0;
            frame_start <= 1'b0;
            h_period    <= '0;
            v_lines     <= '0;
            act_width   <= '0;
            act_height  <= '0;
            err_flag    <= 1'b0;
            err_count   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_s_hs      <= VGA_HS;
            r_d_hs      <= r_s_hs;
            r_s_vs      <= VGA_VS;
            r_d_vs      <= r_s_vs;
            r_s_valid   <= valid_in;
            de_out      <= r_s_valid;
            X           <= r_s_valid ? r_w_cnt   : '0;
            Y           <= r_s_valid ? r_act_cnt : '0;
            frame_start <= w_vs_fall;
            h_period    <= w_h_period_nx;
            act_width   <= w_act_width_nx;

            if (w_hs_fall) begin
                r_h_cnt <= '0;
                r_w_cnt <= '0;
            end else begin
                r_h_cnt <= sat_inc(r_h_cnt);
                if (r_s_valid) r_w_cnt <= sat_inc(r_w_cnt);
            end

            if (w_vs_fall) begin
                v_lines    <= w_lines_nx;
                act_height <= w_act_h_nx;
                r_line_cnt <= '0;
                r_act_cnt  <= '0;
            end else begin
                r_line_cnt <= w_lines_nx;
                r_act_cnt  <= w_act_h_nx;
            end

            if (w_loss) begin
                err_flag <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
